// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory request/acknowledge bus between the fetch stage and a
// variable-latency instruction memory.
//
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : word-aligned fetch byte address (master -> slave)
//   imem_ack   : read data valid, may assert in the request cycle (slave -> master)
//   imem_rdata : instruction word, meaningful only when imem_req & imem_ack
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the fetch
// address register and the IF/ID pipeline register, and fetches from a
// variable-latency instruction memory over a req/ack handshake. There is no
// branch delay slot: a taken redirect squashes the younger fetched word.
//
// Ports:
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous, active-high
//   PC_IFWrite     : 1 = IF/ID and fetch address may advance, 0 = load-use hold
//   Z / J / JR     : branch-taken, jump, register-jump from the decode stage
//   BranchAddr     : branch target
//   JumpAddr       : jump target
//   JrAddr         : register-jump target
//   imem           : instruction memory bus (master side)
//   Instruction_id : IF/ID instruction
//   NextPC_id      : IF/ID address of the instruction + 4
//   PC_if          : current fetch address (trace)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PC_IFWrite,
    input  logic                   Z,
    input  logic                   J,
    input  logic                   JR,
    input  logic [31:0]            BranchAddr,
    input  logic [31:0]            JumpAddr,
    input  logic [31:0]            JrAddr,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            Instruction_id,
    output logic [31:0]            NextPC_id,
    output logic [31:0]            PC_if
);

    // REQ : request outstanding at fa_q
    // HOLD: word already fetched into hold_q, waiting for PC_IFWrite
    // DROP: a redirect arrived before the ack; the in-flight word is thrown away
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fa_q,    fa_d;
    logic [31:0] tgt_q,   tgt_d;
    logic [31:0] hold_q,  hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q,   npc_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] fa_plus4;

    // Redirects are ignored during a load-use hold: ID operands may be stale.
    assign redirect = PC_IFWrite & (JR | J | Z);
    assign target   = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
    assign fa_plus4 = fa_q + 32'd4;

    assign imem.imem_req  = ~reset & (state_q != S_HOLD);
    assign imem.imem_addr = fa_q;

    assign Instruction_id = instr_q;
    assign NextPC_id      = npc_q;
    assign PC_if          = fa_q;

    always_comb begin
        state_d = state_q;
        fa_d    = fa_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        npc_d   = npc_q;

        case (state_q)
            S_REQ: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        fa_d    = target;
                        instr_d = NOP_INSTR;
                        npc_d   = 32'd0;
                    end else if (PC_IFWrite) begin
                        instr_d = imem.imem_rdata;
                        npc_d   = fa_plus4;
                        fa_d    = fa_plus4;
                    end else begin
                        hold_d  = imem.imem_rdata;
                        state_d = S_HOLD;
                    end
                end else begin
                    if (redirect) begin
                        // Address must stay stable until the ack, so park the target.
                        tgt_d   = target;
                        instr_d = NOP_INSTR;
                        npc_d   = 32'd0;
                        state_d = S_DROP;
                    end else if (PC_IFWrite) begin
                        // Bubble while waiting; NextPC_id deliberately kept.
                        instr_d = NOP_INSTR;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    fa_d    = target;
                    instr_d = NOP_INSTR;
                    npc_d   = 32'd0;
                    state_d = S_REQ;
                end else if (PC_IFWrite) begin
                    instr_d = hold_q;
                    npc_d   = fa_plus4;
                    fa_d    = fa_plus4;
                    state_d = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect) begin
                    tgt_d = target;
                end
                if (PC_IFWrite) begin
                    instr_d = NOP_INSTR;
                    npc_d   = 32'd0;
                end
                if (imem.imem_ack) begin
                    // A redirect in the ack cycle is newer than the parked one.
                    fa_d    = redirect ? target : tgt_q;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            fa_q    <= RESET_PC;
            tgt_q   <= 32'd0;
            hold_q  <= 32'd0;
            instr_q <= NOP_INSTR;
            npc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage with a variable-latency memory model
// whose word at byte address A is 32'h1000_0000 + A/4.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_IFWrite;
    logic        Z, J, JR;
    logic [31:0] BranchAddr, JumpAddr, JrAddr;
    logic [31:0] Instruction_id, NextPC_id, PC_if;

    int n_vec = 0;
    int n_err = 0;
    int lat   = 0;
    int cnt   = 0;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_IFWrite     (PC_IFWrite),
        .Z              (Z),
        .J              (J),
        .JR             (JR),
        .BranchAddr     (BranchAddr),
        .JumpAddr       (JumpAddr),
        .JrAddr         (JrAddr),
        .imem           (bus.master),
        .Instruction_id (Instruction_id),
        .NextPC_id      (NextPC_id),
        .PC_if          (PC_if)
    );

    always #5 clk = ~clk;

    // Memory model: acks once a request has been pending for lat cycles.
    assign bus.imem_ack   = bus.imem_req && (cnt == lat);
    assign bus.imem_rdata = 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};

    always @(posedge clk) begin
        if (reset || !bus.imem_req || bus.imem_ack) cnt <= 0;
        else                                        cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0;
        BranchAddr = '0; JumpAddr = '0; JrAddr = '0;

        // Reset state
        step(); step();
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_instr", Instruction_id, 32'd0);
        chk("rst_npc",   NextPC_id, 32'd0);
        chk("rst_pc",    PC_if, 32'd0);
        reset = 1'b0;

        // Zero-wait streaming
        step(); chk("z0_instr", Instruction_id, 32'h1000_0000); chk("z0_npc", NextPC_id, 32'd4);
        step(); chk("z1_instr", Instruction_id, 32'h1000_0001); chk("z1_npc", NextPC_id, 32'd8);
        step(); chk("z2_instr", Instruction_id, 32'h1000_0002); chk("z2_npc", NextPC_id, 32'd12);

        // Two-cycle latency: two bubbles then the word from 12
        lat = 2;
        step(); chk("l2_b0", Instruction_id, 32'd0); chk("l2_addr0", bus.imem_addr, 32'd12);
        chk("l2_npc_keep", NextPC_id, 32'd12);
        step(); chk("l2_b1", Instruction_id, 32'd0); chk("l2_addr1", bus.imem_addr, 32'd12);
        step(); chk("l2_instr", Instruction_id, 32'h1000_0003); chk("l2_npc", NextPC_id, 32'd16);

        // Jump to 0x20, then hold with PC_IFWrite=0 for three cycles
        lat = 0; J = 1'b1; JumpAddr = 32'h20;
        step(); chk("j20_instr", Instruction_id, 32'd0); chk("j20_pc", PC_if, 32'h20);
        J = 1'b0; PC_IFWrite = 1'b0;
        step(); chk("h0_req", {31'd0, bus.imem_req}, 32'd0); chk("h0_instr", Instruction_id, 32'd0);
        Z = 1'b1; BranchAddr = 32'h999;
        step(); chk("h1_req", {31'd0, bus.imem_req}, 32'd0); chk("h1_npc", NextPC_id, 32'd0);
        step(); chk("h2_instr", Instruction_id, 32'd0); chk("h2_pc", PC_if, 32'h20);
        Z = 1'b0; PC_IFWrite = 1'b1;
        step(); chk("hr_instr", Instruction_id, 32'h1000_0008); chk("hr_npc", NextPC_id, 32'h24);
        chk("hr_addr", bus.imem_addr, 32'h24); chk("hr_req", {31'd0, bus.imem_req}, 32'd1);
        step(); chk("h24_instr", Instruction_id, 32'h1000_0009); chk("h24_npc", NextPC_id, 32'h28);

        // Zero-wait jump squashes the acked word
        J = 1'b1; JumpAddr = 32'h400;
        step(); chk("j400_instr", Instruction_id, 32'd0); chk("j400_addr", bus.imem_addr, 32'h400);
        J = 1'b0;
        step(); chk("j400_tgt", Instruction_id, 32'h1000_0100); chk("j400_npc", NextPC_id, 32'h404);

        // Branch while the fetch at 0x10 is outstanding (latency 3)
        J = 1'b1; JumpAddr = 32'h10;
        step(); chk("j10_addr", bus.imem_addr, 32'h10);
        J = 1'b0; lat = 3; Z = 1'b1; BranchAddr = 32'h80;
        step(); chk("d0_addr", bus.imem_addr, 32'h10); chk("d0_instr", Instruction_id, 32'd0);
        Z = 1'b0;
        step(); chk("d1_addr", bus.imem_addr, 32'h10); chk("d1_instr", Instruction_id, 32'd0);
        step(); chk("d2_addr", bus.imem_addr, 32'h10); chk("d2_instr", Instruction_id, 32'd0);
        step(); chk("d3_addr", bus.imem_addr, 32'h80); chk("d3_instr", Instruction_id, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); chk("d_bubble", Instruction_id, 32'd0);
        end
        step(); chk("b80_instr", Instruction_id, 32'h1000_0020); chk("b80_npc", NextPC_id, 32'h84);

        // JR beats J; redirect ignored while PC_IFWrite=0
        lat = 0; JR = 1'b1; J = 1'b1; JrAddr = 32'h100; JumpAddr = 32'h200;
        step(); chk("jr_addr", bus.imem_addr, 32'h100);
        JR = 1'b0; J = 1'b0;
        step(); chk("jr_instr", Instruction_id, 32'h1000_0040); chk("jr_npc", NextPC_id, 32'h104);
        PC_IFWrite = 1'b0; Z = 1'b1; BranchAddr = 32'h300;
        step(); chk("zs_addr", bus.imem_addr, 32'h104); chk("zs_instr", Instruction_id, 32'h1000_0040);
        Z = 1'b0; PC_IFWrite = 1'b1;
        step(); chk("zs_rel", Instruction_id, 32'h1000_0041); chk("zs_npc", NextPC_id, 32'h108);

        // Address wrap at the top of the space
        J = 1'b1; JumpAddr = 32'hFFFF_FFFC;
        step(); chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        J = 1'b0;
        step(); chk("wr_instr", Instruction_id, 32'h4FFF_FFFF); chk("wr_npc", NextPC_id, 32'd0);
        chk("wr_pc", PC_if, 32'd0);

        // Reset in the middle of an outstanding fetch
        lat = 2;
        step();
        reset = 1'b1;
        step(); chk("mr_req", {31'd0, bus.imem_req}, 32'd0); chk("mr_instr", Instruction_id, 32'd0);
        reset = 1'b0;
        step(); chk("mr_b0", Instruction_id, 32'd0); chk("mr_addr", bus.imem_addr, 32'd0);
        step(); chk("mr_b1", Instruction_id, 32'd0);
        step(); chk("mr_instr0", Instruction_id, 32'h1000_0000); chk("mr_npc0", NextPC_id, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
